// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a valid/ready memory
// port, holds the instruction for decode and picks the next PC on retire.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
    output logic        fault,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t      state;
    logic [31:0] next_pc;

    assign pc_plus4      = pc + 32'd4;
    assign next_pc       = pc_src ? pc_target : pc_plus4;
    assign imem_req_addr = pc;
    assign op            = instr[6:0];
    assign func3         = instr[14:12];
    assign func7         = instr[31:25];

    // Handshake flags are registered next to the state so every output comes
    // straight from a flop; no input reaches an output combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            instr          <= NOP_INSTR;
            instret        <= 32'd0;
            fault          <= 1'b0;
            instr_valid    <= 1'b0;
            imem_req_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state          <= FETCH;
                    imem_req_valid <= 1'b1;
                end
                FETCH: begin
                    if (imem_req_ready) begin
                        state          <= WAIT;
                        imem_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        instr       <= imem_rsp_data;
                        state       <= HOLD;
                        instr_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        instret     <= instret + 32'd1;
                        instr_valid <= 1'b0;
                        // A misaligned target keeps the faulting instruction's PC visible.
                        if (next_pc[1:0] != 2'b00) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end else begin
                            pc             <= next_pc;
                            state          <= FETCH;
                            imem_req_valid <= 1'b1;
                        end
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state          <= IDLE;
                    imem_req_valid <= 1'b0;
                    instr_valid    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table for the main flow,
// then hand-written sequences for branches, wrap, faults and async reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'd0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_src = 1'b0;
    logic [31:0] pc_target = 32'd0;
    logic        fault;
    logic [31:0] instret;

    int tests  = 0;
    int failed = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] W0  = 32'h0050_0093;
    localparam logic [31:0] W1  = 32'h0010_0113;
    localparam logic [31:0] W2  = 32'h0020_0193;
    localparam logic [31:0] W3  = 32'h0000_0463;
    localparam logic [31:0] JNK = 32'hDEAD_BEEF;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .op             (op),
        .func3          (func3),
        .func7          (func7),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .pc_src         (pc_src),
        .pc_target      (pc_target),
        .fault          (fault),
        .instret        (instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        rrdy;
        logic        rv;
        logic [31:0] rd;
        logic        ir;
        logic        src;
        logic [31:0] tgt;
        logic        e_rv;
        logic        e_iv;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_ret;
        logic        e_f;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic rrdy, logic rv, logic [31:0] rd,
                                logic ir, logic src, logic [31:0] tgt,
                                logic e_rv, logic e_iv, logic [31:0] e_instr,
                                logic [31:0] e_pc, logic [31:0] e_ret, logic e_f);
        vec_t v;
        v.rst = r; v.rrdy = rrdy; v.rv = rv; v.rd = rd; v.ir = ir; v.src = src; v.tgt = tgt;
        v.e_rv = e_rv; v.e_iv = e_iv; v.e_instr = e_instr; v.e_pc = e_pc; v.e_ret = e_ret; v.e_f = e_f;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic rrdy, input logic rv, input logic [31:0] rd,
                       input logic ir, input logic src, input logic [31:0] tgt);
        @(negedge clk);
        imem_req_ready = rrdy; imem_rsp_valid = rv; imem_rsp_data = rd;
        instr_ready = ir; pc_src = src; pc_target = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_word(input logic [31:0] data);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b1, data, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic retire(input logic src, input logic [31:0] tgt);
        cyc(1'b0, 1'b0, 32'd0, 1'b1, src, tgt);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; instr_ready = 1'b0; pc_src = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // rst rrdy rv rd  ir src tgt | rv iv instr pc ret f
        tbl.push_back(mk(1, 0, 0, 0,   0, 0, 0,        0, 0, NOP, 32'h0,  0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0,        1, 0, NOP, 32'h0,  0, 0));
        tbl.push_back(mk(0, 1, 0, 0,   0, 0, 0,        0, 0, NOP, 32'h0,  0, 0));
        tbl.push_back(mk(0, 0, 1, W0,  0, 0, 0,        0, 1, W0,  32'h0,  0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   1, 0, 0,        1, 0, W0,  32'h4,  1, 0));
        tbl.push_back(mk(0, 1, 0, 0,   1, 1, 32'h100,  0, 0, W0,  32'h4,  1, 0));
        tbl.push_back(mk(0, 0, 1, W1,  1, 0, 0,        0, 1, W1,  32'h4,  1, 0));
        tbl.push_back(mk(0, 0, 0, 0,   1, 0, 0,        1, 0, W1,  32'h8,  2, 0));
        tbl.push_back(mk(0, 1, 0, 0,   1, 1, 32'h100,  0, 0, W1,  32'h8,  2, 0));
        tbl.push_back(mk(0, 0, 1, W2,  1, 0, 0,        0, 1, W2,  32'h8,  2, 0));
        tbl.push_back(mk(0, 0, 0, 0,   1, 0, 0,        1, 0, W2,  32'hC,  3, 0));
        tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0,        1, 0, W2,  32'hC,  3, 0));
        tbl.push_back(mk(0, 0, 1, JNK, 0, 0, 0,        1, 0, W2,  32'hC,  3, 0));
        tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0,        1, 0, W2,  32'hC,  3, 0));
        tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0,        1, 0, W2,  32'hC,  3, 0));
        tbl.push_back(mk(0, 1, 0, 0,   0, 0, 0,        0, 0, W2,  32'hC,  3, 0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,      0, 0, W2,  32'hC,  3, 0));
        tbl.push_back(mk(0, 0, 1, W3,  0, 0, 0,        0, 1, W3,  32'hC,  3, 0));
        tbl.push_back(mk(0, 0, 0, 0,   0, 1, 32'h80,   0, 1, W3,  32'hC,  3, 0));
        tbl.push_back(mk(0, 0, 0, 0,   1, 0, 0,        1, 0, W3,  32'h10, 4, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].rst;
            imem_req_ready = tbl[i].rrdy; imem_rsp_valid = tbl[i].rv; imem_rsp_data = tbl[i].rd;
            instr_ready = tbl[i].ir; pc_src = tbl[i].src; pc_target = tbl[i].tgt;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d req_valid", i), {31'd0, imem_req_valid}, {31'd0, tbl[i].e_rv});
            chk($sformatf("v%0d req_addr", i), imem_req_addr, tbl[i].e_pc);
            chk($sformatf("v%0d instr_valid", i), {31'd0, instr_valid}, {31'd0, tbl[i].e_iv});
            chk($sformatf("v%0d instr", i), instr, tbl[i].e_instr);
            chk($sformatf("v%0d op", i), {25'd0, op}, {25'd0, tbl[i].e_instr[6:0]});
            chk($sformatf("v%0d func3", i), {29'd0, func3}, {29'd0, tbl[i].e_instr[14:12]});
            chk($sformatf("v%0d func7", i), {25'd0, func7}, {25'd0, tbl[i].e_instr[31:25]});
            chk($sformatf("v%0d pc", i), pc, tbl[i].e_pc);
            chk($sformatf("v%0d pc_plus4", i), pc_plus4, tbl[i].e_pc + 32'd4);
            chk($sformatf("v%0d instret", i), instret, tbl[i].e_ret);
            chk($sformatf("v%0d fault", i), {31'd0, fault}, {31'd0, tbl[i].e_f});
        end

        // Branch taken / not taken, PC wrap, then misaligned-target fault.
        do_reset();
        cyc(0, 0, 0, 0, 0, 0);
        fetch_word(W0); retire(0, 0);
        fetch_word(W1); retire(0, 0);
        chk("seq_addr_8", imem_req_addr, 32'h8);
        fetch_word(W2);
        chk("hold_pc_8", pc, 32'h8);
        retire(1, 32'h40);
        chk("branch_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("branch_addr", imem_req_addr, 32'h40);
        fetch_word(W0); retire(1, 32'hFFFF_FFFC);
        chk("jump_top_addr", imem_req_addr, 32'hFFFF_FFFC);
        fetch_word(W1);
        chk("top_pc_plus4", pc_plus4, 32'h0);
        retire(0, 0);
        chk("wrap_addr", imem_req_addr, 32'h0);
        chk("wrap_instret", instret, 32'd5);
        fetch_word(W0); retire(1, 32'h8);
        fetch_word(W2); retire(1, 32'h42);
        chk("misalign_fault", {31'd0, fault}, 32'd1);
        chk("misalign_pc", pc, 32'h8);
        chk("misalign_instret", instret, 32'd7);
        chk("misalign_iv", {31'd0, instr_valid}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 1, JNK, 1, 0, 0);
            chk($sformatf("fault_no_req%0d", k), {31'd0, imem_req_valid}, 32'd0);
            chk($sformatf("fault_sticky%0d", k), {31'd0, fault}, 32'd1);
        end
        do_reset();
        chk("fault_cleared", {31'd0, fault}, 32'd0);
        chk("fault_reset_pc", pc, 32'h0);

        // Async reset in WAIT, then a stale response while IDLE.
        cyc(0, 0, 0, 0, 0, 0);
        fetch_word(W0); retire(0, 0);
        chk("pre_rst_instret", instret, 32'd1);
        cyc(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        imem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_pc", pc, 32'h0);
        chk("async_instret", instret, 32'd0);
        chk("async_instr", instr, NOP);
        chk("async_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("async_iv", {31'd0, instr_valid}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = JNK;
        @(posedge clk);
        #1;
        chk("stale_instr", instr, NOP);
        chk("restart_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("restart_addr", imem_req_addr, 32'h0);
        cyc(0, 1, JNK, 0, 0, 0);
        chk("stale_fetch_instr", instr, NOP);
        chk("stale_fetch_iv", {31'd0, instr_valid}, 32'd0);
        fetch_word(W1);
        chk("restart_instr", instr, W1);
        chk("restart_iv", {31'd0, instr_valid}, 32'd1);
        chk("restart_instret", instret, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
